// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 joystick shift-chain transmitter.
// Contents: default chain geometry, transmitter FSM state type, and the
// button bit positions within one player's button word.
package joy_db15_pkg;

  localparam int unsigned DEFAULT_PLAYER_BITS = 12;
  localparam int unsigned CHAIN_LEN           = 2 * DEFAULT_PLAYER_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } db15_tx_state_t;

  // Bit positions inside a player's button word (1 = pressed)
  localparam int unsigned BTN_R  = 0;
  localparam int unsigned BTN_L  = 1;
  localparam int unsigned BTN_D  = 2;
  localparam int unsigned BTN_U  = 3;
  localparam int unsigned BTN_B1 = 4;
  localparam int unsigned BTN_B2 = 5;
  localparam int unsigned BTN_B3 = 6;
  localparam int unsigned BTN_B4 = 7;
  localparam int unsigned BTN_B5 = 8;
  localparam int unsigned BTN_B6 = 9;
  localparam int unsigned BTN_B7 = 10;
  localparam int unsigned BTN_B8 = 11;

endpackage

// File: rtl/joy_db15_tx_sync_filter.sv
// Synchronizer plus glitch filter for one asynchronous control line.
//   clk_i    : system clock
//   reset_i  : synchronous active-high reset (accepted level returns to 1)
//   async_i  : asynchronous input line
//   level_o  : filtered level, changes only after FILT equal samples
//   rise_o   : one-cycle strobe, registered with the accepted 0->1 change
//   fall_o   : one-cycle strobe, registered with the accepted 1->0 change
module sync_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT        = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = (FILT > 1) ? $clog2(FILT) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   samp;
  logic                   accept;

  assign samp = sync_q[SYNC_STAGES-1];
  // cnt_q counts earlier consecutive differing samples; this one is the FILT-th
  assign accept = (samp != level_q) && (cnt_q == CW'(FILT - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q[0] <= async_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      rise_q <= accept & samp;
      fall_q <= accept & ~samp;
      if (samp == level_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        level_q <= samp;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick shift-chain transmitter: emulates the two-player
// parallel-in/serial-out chain of a DB15 adapter in the clk_sys domain.
//   clk_sys    : system clock
//   reset      : synchronous active-high reset
//   joy_clk    : asynchronous shift clock from the reader
//   joy_load   : asynchronous active-low parallel load from the reader
//   joystick1  : player 1 buttons (1 = pressed), leads the chain MSB first
//   joystick2  : player 2 buttons, follows player 1
//   joy_data   : registered serial data, active-low, 1 when idle/done
//   frame_done : one-cycle pulse on completion of a full chain
//   bit_cnt    : shifts since last load, saturating at 2*PLAYER_BITS
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int unsigned PLAYER_BITS = DEFAULT_PLAYER_BITS,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT        = 2
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic                   joy_clk,
  input  logic                   joy_load,
  input  logic [PLAYER_BITS-1:0] joystick1,
  input  logic [PLAYER_BITS-1:0] joystick2,
  output logic                   joy_data,
  output logic                   frame_done,
  output logic [4:0]             bit_cnt
);

  localparam int unsigned CHAIN     = 2 * PLAYER_BITS;
  localparam logic [4:0]  CHAIN_CNT = 5'(CHAIN);

  logic clk_f, clk_rise, clk_fall;
  logic load_f, load_rise, load_fall;
  logic unused_edges;

  sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT(FILT)) u_clk_filt (
    .clk_i   (clk_sys),
    .reset_i (reset),
    .async_i (joy_clk),
    .level_o (clk_f),
    .rise_o  (clk_rise),
    .fall_o  (clk_fall)
  );

  sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT(FILT)) u_load_filt (
    .clk_i   (clk_sys),
    .reset_i (reset),
    .async_i (joy_load),
    .level_o (load_f),
    .rise_o  (load_rise),
    .fall_o  (load_fall)
  );

  // The FSM works from the load level and the clock rise strobe only
  assign unused_edges = ^{clk_f, clk_fall, load_rise, load_fall};

  db15_tx_state_t   state_q, state_d;
  logic [CHAIN-1:0] sreg_q, sreg_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             data_q, data_d;
  logic             done_q, done_d;
  logic [CHAIN-1:0] chain;

  assign chain = ~{joystick1, joystick2};

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    // Load level has priority over everything, so a clock rise in the
    // same cycle as the load fall never shifts.
    if (!load_f) begin
      state_d = ST_LOAD;
      sreg_d  = chain;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_LOAD:  state_d = ST_SHIFT;
        ST_SHIFT: begin
          if (cnt_q == CHAIN_CNT) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (clk_rise) begin
            sreg_d = {sreg_q[CHAIN-2:0], 1'b1};
            cnt_d  = cnt_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
    data_d = ((state_d == ST_LOAD) || (state_d == ST_SHIFT)) ? sreg_d[CHAIN-1] : 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sreg_q  <= '1;
      cnt_q   <= '0;
      data_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign joy_data   = data_q;
  assign frame_done = done_q;
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
module tb_joy_db15_tx;

  localparam int PB = 12;
  localparam int CL = 2 * PB;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          joy_clk;
  logic          joy_load;
  logic [PB-1:0] joystick1;
  logic [PB-1:0] joystick2;
  logic          joy_data;
  logic          frame_done;
  logic [4:0]    bit_cnt;

  int total = 0;
  int bad   = 0;
  int done_seen = 0;

  joy_db15_tx #(.PLAYER_BITS(PB), .SYNC_STAGES(2), .FILT(2)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .joy_data   (joy_data),
    .frame_done (frame_done),
    .bit_cnt    (bit_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  // Advance n cycles, sampling 1 ns after each rising edge
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
      if (frame_done === 1'b1) done_seen++;
    end
  endtask

  function automatic int ph();
    return int'($urandom_range(8, 12));
  endfunction

  // Reference: chain position k counted from the first bit out.
  function automatic logic exp_bit(input int k);
    if (k >= CL)      return 1'b1;
    else if (k < PB)  return ~joystick1[PB-1-k];
    else              return ~joystick2[CL-1-k];
  endfunction

  function automatic int exp_cnt(input int k);
    return (k > CL) ? CL : k;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Load low phase (with a live joystick change), then load released
  task automatic start_frame(input logic [PB-1:0] j1, input logic [PB-1:0] j2);
    joystick1 = ~j1;
    joystick2 = j2;
    joy_clk   = 1'b0;
    joy_load  = 1'b0;
    done_seen = 0;
    cyc(ph());
    joystick1 = j1;
    cyc(ph());
    chk("load_data", int'(joy_data), int'(exp_bit(0)));
    chk("load_cnt", int'(bit_cnt), 0);
    joy_load = 1'b1;
    cyc(ph());
    chk("post_load_data", int'(joy_data), int'(exp_bit(0)));
  endtask

  task automatic shift_clocks(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      joy_clk = 1'b1;
      cyc(ph());
      chk("shift_data", int'(joy_data), int'(exp_bit(k)));
      chk("shift_cnt", int'(bit_cnt), exp_cnt(k));
      joy_clk = 1'b0;
      cyc(ph());
    end
  endtask

  initial begin
    logic [PB-1:0] r1, r2;
    int n;

    // Reset with idle-high inputs
    reset = 1'b1; joy_clk = 1'b1; joy_load = 1'b1;
    joystick1 = '0; joystick2 = '0;
    cyc(4);
    chk("rst_data", int'(joy_data), 1);
    chk("rst_cnt", int'(bit_cnt), 0);
    chk("rst_done", int'(frame_done), 0);
    reset = 1'b0;
    done_seen = 0;
    cyc(12);
    chk("idle_data", int'(joy_data), 1);
    chk("idle_cnt", int'(bit_cnt), 0);
    chk("idle_done", done_seen, 0);

    // Single pressed R on player 1: only chain bit 11 is low
    start_frame(12'h001, 12'h000);
    shift_clocks(1, CL - 1);
    chk("done_early", done_seen, 0);
    shift_clocks(CL, CL);
    chk("done_once_a", done_seen, 1);

    // All pressed / alternating, plus extra clocks in DONE
    start_frame(12'hFFF, 12'hAAA);
    shift_clocks(1, CL + 2);
    chk("done_once_b", done_seen, 1);
    chk("done_data", int'(joy_data), 1);
    chk("done_cnt", int'(bit_cnt), CL);

    // Random frames
    for (int f = 0; f < 4; f++) begin
      r1 = PB'($urandom); r2 = PB'($urandom);
      n  = CL + int'($urandom_range(0, 2));
      start_frame(r1, r2);
      shift_clocks(1, n);
      chk("done_rand", done_seen, 1);
    end

    // One-cycle glitch on joy_clk mid-frame is rejected
    r1 = PB'($urandom); r2 = PB'($urandom);
    start_frame(r1, r2);
    shift_clocks(1, 5);
    @(posedge clk_sys); #1; joy_clk = 1'b1;
    @(posedge clk_sys); #1; joy_clk = 1'b0;
    cyc(ph());
    chk("glitch_cnt", int'(bit_cnt), 5);
    chk("glitch_data", int'(joy_data), int'(exp_bit(5)));
    shift_clocks(6, CL);
    chk("glitch_done", done_seen, 1);

    // Load and clock rise together mid-frame: load wins
    start_frame(PB'($urandom), PB'($urandom));
    shift_clocks(1, 7);
    joystick1 = PB'($urandom); joystick2 = PB'($urandom);
    joy_load = 1'b0; joy_clk = 1'b1;
    done_seen = 0;
    cyc(ph());
    chk("lc_cnt", int'(bit_cnt), 0);
    chk("lc_data", int'(joy_data), int'(exp_bit(0)));
    joy_load = 1'b1; joy_clk = 1'b0;
    cyc(ph());
    chk("lc_hold_cnt", int'(bit_cnt), 0);
    chk("lc_hold_data", int'(joy_data), int'(exp_bit(0)));
    shift_clocks(1, CL);
    chk("lc_done", done_seen, 1);

    // Reset at bit 7 returns to idle; clocks without load do nothing
    start_frame(12'h000, 12'h000);
    shift_clocks(1, 7);
    reset = 1'b1;
    cyc(1);
    chk("mid_rst_data", int'(joy_data), 1);
    chk("mid_rst_cnt", int'(bit_cnt), 0);
    reset = 1'b0;
    done_seen = 0;
    cyc(ph());
    for (int k = 0; k < 2; k++) begin
      joy_clk = 1'b1; cyc(ph());
      joy_clk = 1'b0; cyc(ph());
    end
    chk("post_rst_data", int'(joy_data), 1);
    chk("post_rst_cnt", int'(bit_cnt), 0);
    chk("post_rst_done", done_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
